// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised multi-cycle CPU: opcodes, FSM states,
// ALU selects and the decode helpers used by cpu_multicycle_param.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_ADDI = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_JNZ  = 4'hB,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_t;

    // Only the data-processing opcodes write the register file; C-E fall out as NOP.
    function automatic logic writes_reg(input opcode_t op);
        return op inside {OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI};
    endfunction

    function automatic alu_op_t alu_sel(input opcode_t op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND:          return ALU_AND;
            OP_OR:           return ALU_OR;
            OP_XOR:          return ALU_XOR;
            default:         return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU of the multi-cycle CPU; all arithmetic wraps modulo 2^DATA_W.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_t           sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = b;
        case (sel)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            default: y = b;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle_param.sv
// Parametrised multi-cycle CPU: IDLE -> FETCH -> DECODE -> EXEC -> FETCH | HALT.
// Define CPU_BRANCH_EN to make JZ/JNZ take their branch; otherwise they behave as NOP.
module cpu_multicycle_param
    import cpu_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 4,
    parameter  int ADDR_W = 16,
    parameter  int IMM_W  = 8,
    localparam int RW     = $clog2(NREG),
    localparam int INS_W  = 4 + 2 * RW + IMM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic              en_ram_out,
    input  logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] addr,
    output logic              en_ram_in,
    output logic              wb_en,
    output logic [RW-1:0]     wb_idx,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              halted
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ir;
    logic [DATA_W-1:0] regs [NREG];

    opcode_t           op;
    logic [RW-1:0]     rd;
    logic [RW-1:0]     rs;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              jump;
    logic [ADDR_W-1:0] jump_pc;

    assign op     = opcode_t'(ir[INS_W-1 -: 4]);
    assign rd     = ir[2*RW+IMM_W-1 -: RW];
    assign rs     = ir[RW+IMM_W-1 -: RW];
    assign imm    = ir[IMM_W-1:0];
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];
    assign addr   = pc;

    always_comb begin
        case (op)
            OP_LDI:  alu_b = DATA_W'(imm);
            OP_ADDI: alu_b = DATA_W'($signed(imm));
            default: alu_b = rs_val;
        endcase
    end

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .sel (alu_sel(op)),
        .a   (rd_val),
        .b   (alu_b),
        .y   (alu_y)
    );

    // pc already points past the current instruction when EXEC evaluates a branch.
    always_comb begin
        jump    = 1'b0;
        jump_pc = pc + ADDR_W'($signed(imm));
        case (op)
            OP_JMP: begin
                jump    = 1'b1;
                jump_pc = ADDR_W'(imm);
            end
`ifdef CPU_BRANCH_EN
            OP_JZ:   jump = (rd_val == '0);
            OP_JNZ:  jump = (rd_val != '0);
`endif
            default: jump = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            en_ram_in <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            wb_en     <= 1'b0;
            wb_idx    <= '0;
            wb_data   <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en_in) begin
                        state     <= S_FETCH;
                        en_ram_in <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (en_ram_out) begin
                        ir        <= ins;
                        pc        <= pc + ADDR_W'(1);
                        en_ram_in <= 1'b0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    wb_en   <= writes_reg(op);
                    wb_idx  <= rd;
                    wb_data <= alu_y;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (wb_en) regs[wb_idx] <= wb_data;
                    if (jump) pc <= jump_pc;
                    if (op == OP_HALT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state     <= S_FETCH;
                        en_ram_in <= 1'b1;
                    end
                end
                S_HALT: state <= S_HALT;
                default: begin
                    state     <= S_IDLE;
                    en_ram_in <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
